gb_apu_channel_pulse_gen: RTL

Parametrised next-generation pulse channel for the APU. It integrates the period divider, sweep, envelope, length and DAC gating into a single one-clock, asynchronously reset block. Frame-sequencer ticks arrive as one-cycle strobes synchronous to clk. Compared with the fixed channel, it adds a selectable custom duty pattern, configurable divider width, prescale and step count, DAC-off gating, and a wave-step strobe for the mixer and debug.

---
 rtl/gb_apu_pkg.sv | 25 ++
 rtl/gb_apu_channel_pulse_gen_if.sv | 49 ++++
 rtl/gb_apu_sweep_unit.sv | 83 ++++++++
 rtl/gb_apu_channel_pulse_gen.sv | 156 +++++++++++++++
 4 files changed

// File: rtl/gb_apu_pkg.sv
// Shared types and constants for the APU pulse channel: volume type, standard
// duty table and sweep direction.
package gb_apu_pkg;

  localparam int unsigned VOL_W        = 4;
  localparam int unsigned DUTY_TABLE_W = 8;

  typedef logic [VOL_W-1:0] vol_t;

  localparam vol_t VOL_MAX = 4'hF;

  // Index by wave_duty; bit i is the output level at waveform step i.
  localparam logic [3:0][DUTY_TABLE_W-1:0] DUTY_TABLE = {
    8'b0011_1111,
    8'b1111_0000,
    8'b1100_0000,
    8'b1000_0000
  };

  typedef enum logic {
    INC = 1'b0,
    DEC = 1'b1
  } sweep_op_t;

endpackage

// File: rtl/gb_apu_channel_pulse_gen_if.sv
// Control/status bundle between the register file (master) and the pulse
// channel (slave).
interface gb_apu_channel_pulse_gen_if
  import gb_apu_pkg::*;
#(
  parameter int unsigned PERIOD_W   = 11,
  parameter int unsigned LENGTH_W   = 6,
  parameter int unsigned DUTY_STEPS = 8
);

  logic                  tick_length;
  logic                  tick_env;
  logic                  tick_sweep;
  logic                  trigger;
  logic [PERIOD_W-1:0]   frequency;
  logic [2:0]            sweep_time;
  logic                  sweep_decreasing;
  logic [2:0]            num_sweep_shifts;
  logic [1:0]            wave_duty;
  logic                  duty_custom;
  logic [DUTY_STEPS-1:0] custom_pattern;
  logic [LENGTH_W-1:0]   length;
  logic                  single;
  vol_t                  initial_volume;
  logic                  envelope_increasing;
  logic [2:0]            num_envelope_sweeps;

  vol_t                  level;
  logic                  enable;
  logic                  dac_on;
  logic                  wave_step;

  modport master (
    output tick_length, tick_env, tick_sweep, trigger, frequency, sweep_time,
           sweep_decreasing, num_sweep_shifts, wave_duty, duty_custom,
           custom_pattern, length, single, initial_volume, envelope_increasing,
           num_envelope_sweeps,
    input  level, enable, dac_on, wave_step
  );

  modport slave (
    input  tick_length, tick_env, tick_sweep, trigger, frequency, sweep_time,
           sweep_decreasing, num_sweep_shifts, wave_duty, duty_custom,
           custom_pattern, length, single, initial_volume, envelope_increasing,
           num_envelope_sweeps,
    output level, enable, dac_on, wave_step
  );

endinterface

// File: rtl/gb_apu_sweep_unit.sv
// Frequency sweep: shadow frequency register, sweep pace timer and the
// overflow check that silences the channel.
module gb_apu_sweep_unit
  import gb_apu_pkg::*;
#(
  parameter int unsigned PERIOD_W = 11
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                trig_p_i,
  input  logic                tick_i,
  input  logic [PERIOD_W-1:0] frequency_i,
  input  logic [2:0]          sweep_time_i,
  input  logic                sweep_decreasing_i,
  input  logic [2:0]          shifts_i,
  output logic [PERIOD_W-1:0] shadow_o,
  output logic                overflow_c
);

  localparam int unsigned CALC_W  = PERIOD_W + 1;
  localparam int unsigned TIMER_W = 4;

  logic [PERIOD_W-1:0] shadow_q, shadow_d;
  logic [TIMER_W-1:0]  timer_q, timer_d;
  logic [TIMER_W-1:0]  timer_reload;
  logic [CALC_W-1:0]   new_freq, recheck, trig_check;
  sweep_op_t           op;

  // One extra bit so an increment past the period range shows up as the MSB.
  function automatic logic [CALC_W-1:0] sweep_calc(input logic [PERIOD_W-1:0] f,
                                                   input logic [2:0]          sh,
                                                   input sweep_op_t           o);
    logic [CALC_W-1:0] base;
    logic [CALC_W-1:0] delta;
    base  = CALC_W'(f);
    delta = CALC_W'(f >> sh);
    return (o == DEC) ? (base - delta) : (base + delta);
  endfunction

  always_comb begin
    op           = sweep_decreasing_i ? DEC : INC;
    shadow_d     = shadow_q;
    timer_d      = timer_q;
    overflow_c   = 1'b0;
    timer_reload = (sweep_time_i == 3'd0) ? TIMER_W'(8) : TIMER_W'(sweep_time_i);
    new_freq     = sweep_calc(shadow_q, shifts_i, op);
    recheck      = sweep_calc(new_freq[PERIOD_W-1:0], shifts_i, op);
    trig_check   = sweep_calc(frequency_i, shifts_i, op);

    if (trig_p_i) begin
      shadow_d   = frequency_i;
      timer_d    = timer_reload;
      overflow_c = (shifts_i != 3'd0) && trig_check[PERIOD_W];
    end else if (tick_i) begin
      if (timer_q <= TIMER_W'(1)) begin
        timer_d = timer_reload;
        if (sweep_time_i != 3'd0) begin
          if (new_freq[PERIOD_W]) begin
            overflow_c = 1'b1;
          end else if (shifts_i != 3'd0) begin
            shadow_d   = new_freq[PERIOD_W-1:0];
            overflow_c = recheck[PERIOD_W];
          end
        end
      end else begin
        timer_d = timer_q - TIMER_W'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      shadow_q <= '0;
      timer_q  <= '0;
    end else begin
      shadow_q <= shadow_d;
      timer_q  <= timer_d;
    end
  end

  assign shadow_o = shadow_q;

endmodule

// File: rtl/gb_apu_channel_pulse_gen.sv
// Pulse channel: prescaled period divider, duty pattern, envelope, length
// counter, optional sweep and DAC gating into a registered 4-bit level.
module gb_apu_channel_pulse_gen
  import gb_apu_pkg::*;
#(
  parameter int unsigned PERIOD_W   = 11,
  parameter int unsigned LENGTH_W   = 6,
  parameter int unsigned PRESCALE   = 4,
  parameter int unsigned DUTY_STEPS = 8,
  parameter int unsigned SWEEP_EN   = 1
) (
  input  logic                       clk,
  input  logic                       reset,
  gb_apu_channel_pulse_gen_if.slave  bus
);

  localparam int unsigned STEP_W = $clog2(DUTY_STEPS);
  localparam int unsigned PS_W   = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam int unsigned ENV_W  = 3;
  localparam logic [PS_W-1:0] PS_RELOAD = PS_W'(PRESCALE - 1);

  logic                  trig_q, trig_d;
  logic [STEP_W-1:0]     step_q, step_d;
  logic [PERIOD_W-1:0]   divider_q, divider_d;
  logic [PS_W-1:0]       prescaler_q, prescaler_d;
  vol_t                  volume_q, volume_d;
  logic [ENV_W-1:0]      env_timer_q, env_timer_d;
  logic [LENGTH_W-1:0]   len_cnt_q, len_cnt_d;
  logic                  enable_q, enable_d;
  vol_t                  level_q, level_d;
  logic                  wave_step_q, wave_step_d;

  logic                  trig_p;
  logic                  dac_on_c;
  logic [DUTY_STEPS-1:0] pattern;
  logic [PERIOD_W-1:0]   shadow;
  logic                  sweep_ovf;

  assign trig_p   = bus.trigger & ~trig_q;
  assign dac_on_c = |{bus.initial_volume, bus.envelope_increasing};
  assign pattern  = bus.duty_custom ? bus.custom_pattern
                                    : DUTY_STEPS'(DUTY_TABLE[bus.wave_duty]);

  if (SWEEP_EN != 0) begin : g_sweep
    gb_apu_sweep_unit #(
      .PERIOD_W (PERIOD_W)
    ) u_sweep (
      .clk                (clk),
      .reset              (reset),
      .trig_p_i           (trig_p),
      .tick_i             (bus.tick_sweep & enable_q),
      .frequency_i        (bus.frequency),
      .sweep_time_i       (bus.sweep_time),
      .sweep_decreasing_i (bus.sweep_decreasing),
      .shifts_i           (bus.num_sweep_shifts),
      .shadow_o           (shadow),
      .overflow_c         (sweep_ovf)
    );
  end else begin : g_no_sweep
    assign shadow    = bus.frequency;
    assign sweep_ovf = 1'b0;
  end

  // Next-state for divider, envelope, length and enable; trigger wins over ticks.
  always_comb begin
    trig_d      = bus.trigger;
    step_d      = step_q;
    divider_d   = divider_q;
    prescaler_d = prescaler_q;
    volume_d    = volume_q;
    env_timer_d = env_timer_q;
    len_cnt_d   = len_cnt_q;
    enable_d    = enable_q;
    wave_step_d = 1'b0;
    level_d     = (enable_q && pattern[step_q]) ? volume_q : vol_t'(0);

    if (trig_p) begin
      step_d      = '0;
      divider_d   = bus.frequency;
      prescaler_d = PS_RELOAD;
      volume_d    = bus.initial_volume;
      env_timer_d = bus.num_envelope_sweeps;
      len_cnt_d   = bus.length;
      enable_d    = dac_on_c & ~sweep_ovf;
    end else begin
      if (prescaler_q == '0) begin
        prescaler_d = PS_RELOAD;
        if (&divider_q) begin
          divider_d   = shadow;
          step_d      = step_q + STEP_W'(1);
          wave_step_d = 1'b1;
        end else begin
          divider_d = divider_q + PERIOD_W'(1);
        end
      end else begin
        prescaler_d = prescaler_q - PS_W'(1);
      end

      if (bus.tick_length && enable_q) begin
        len_cnt_d = len_cnt_q + LENGTH_W'(1);
        if ((&len_cnt_q) && bus.single) begin
          enable_d = 1'b0;
        end
      end

      if (bus.tick_env && enable_q && (bus.num_envelope_sweeps != 3'd0)) begin
        if (env_timer_q <= ENV_W'(1)) begin
          env_timer_d = bus.num_envelope_sweeps;
          if (bus.envelope_increasing) begin
            if (volume_q != VOL_MAX) volume_d = volume_q + vol_t'(1);
          end else begin
            if (volume_q != vol_t'(0)) volume_d = volume_q - vol_t'(1);
          end
        end else begin
          env_timer_d = env_timer_q - ENV_W'(1);
        end
      end

      if (sweep_ovf) enable_d = 1'b0;
    end

    if (!dac_on_c) enable_d = 1'b0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      trig_q      <= 1'b0;
      step_q      <= '0;
      divider_q   <= '0;
      prescaler_q <= '0;
      volume_q    <= '0;
      env_timer_q <= '0;
      len_cnt_q   <= '0;
      enable_q    <= 1'b0;
      level_q     <= '0;
      wave_step_q <= 1'b0;
    end else begin
      trig_q      <= trig_d;
      step_q      <= step_d;
      divider_q   <= divider_d;
      prescaler_q <= prescaler_d;
      volume_q    <= volume_d;
      env_timer_q <= env_timer_d;
      len_cnt_q   <= len_cnt_d;
      enable_q    <= enable_d;
      level_q     <= level_d;
      wave_step_q <= wave_step_d;
    end
  end

  assign bus.level     = level_q;
  assign bus.enable    = enable_q;
  assign bus.wave_step = wave_step_q;
  assign bus.dac_on    = dac_on_c;

endmodule
